tx_packet_sched: RTL



---
 rtl/rs232_pkg.sv | 18 +
 rtl/tx_rr_arbiter.sv | 44 ++++
 rtl/tx_packet_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 packet transmit path.
package rs232_pkg;

  localparam int PKT_W        = 64;
  localparam int BIT_TIME_DE0 = 1302;  // one bit time at the DE0 system clock

  localparam logic REQ_AES = 1'b0;
  localparam logic REQ_MSG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-requester grant logic for the packet scheduler.
// TX_SCHED_RR_EN selects round-robin tie-breaking; otherwise AES has fixed priority.
module tx_rr_arbiter
  import rs232_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_aes,
  input  logic req_msg,
  input  logic upd_en,
  input  logic upd_id,
  output logic gnt_vld,
  output logic gnt_id
);

  logic tie_id;

`ifdef TX_SCHED_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd_en) last_d = upd_id;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_MSG;
    else     last_q <= last_d;
  end

  assign tie_id = (last_q == REQ_AES) ? REQ_MSG : REQ_AES;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, upd_en, upd_id};
  assign tie_id    = REQ_AES;
`endif

  always_comb begin
    gnt_vld = req_aes | req_msg;
    gnt_id  = req_aes ? REQ_AES : REQ_MSG;
    if (req_aes && req_msg) gnt_id = tie_id;
  end

endmodule

// File: rtl/tx_packet_sched.sv
// Shares the single 64-bit RS232 packet transmitter between the AES core and the control path.
// Build macro TX_SCHED_RR_EN enables round-robin arbitration (default: AES priority).
//
// state      | meaning
// IDLE       | waiting for a requester; grant and accept payload
// START      | one-cycle tx_start pulse, tx_data already valid
// WAIT_BUSY  | waiting for tx_busy to rise; retry or drop on timeout
// WAIT_DONE  | transmitter sending; wait for tx_busy to fall
// GAP        | inter-packet gap, then next half or done pulse
module tx_packet_sched
  import rs232_pkg::*;
#(
  parameter int BUSY_WAIT_MAX = 64,
  parameter int GAP_CYCLES    = BIT_TIME_DE0,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               aes_valid,
  input  logic [2*PKT_W-1:0] aes_data,
  output logic               aes_ready,
  input  logic               msg_valid,
  input  logic [PKT_W-1:0]   msg_data,
  output logic               msg_ready,
  output logic [PKT_W-1:0]   tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               aes_done,
  output logic               msg_done,
  output logic               err_drop
);

  localparam int WAIT_W = $clog2(BUSY_WAIT_MAX);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int RTRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
  localparam logic [RTRY_W-1:0] RTRY_LAST = RTRY_W'(MAX_RETRY - 1);

  tx_state_e         state_q, state_d;
  logic [1:0]        pkt_left_q, pkt_left_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              owner_q, owner_d;
  logic [PKT_W-1:0]  tx_data_q, tx_data_d;
  logic [PKT_W-1:0]  hi_half_q, hi_half_d;
  logic              gnt_vld, gnt_id, burst_done;

  tx_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_aes (aes_valid),
    .req_msg (msg_valid),
    .upd_en  (burst_done),
    .upd_id  (owner_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pkt_left_q <= '0;
      retry_q    <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      owner_q    <= REQ_MSG;
      tx_data_q  <= '0;
      hi_half_q  <= '0;
    end else begin
      state_q    <= state_d;
      pkt_left_q <= pkt_left_d;
      retry_q    <= retry_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      hi_half_q  <= hi_half_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_left_d = pkt_left_q;
    retry_d    = retry_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    hi_half_d  = hi_half_q;
    case (state_q)
      ST_IDLE: begin
        if (aes_valid && aes_ready) begin
          owner_d    = REQ_AES;
          pkt_left_d = 2'd2;
          retry_d    = '0;
          tx_data_d  = aes_data[PKT_W-1:0];
          hi_half_d  = aes_data[2*PKT_W-1:PKT_W];
          state_d    = ST_START;
        end else if (msg_valid && msg_ready) begin
          owner_d    = REQ_MSG;
          pkt_left_d = 2'd1;
          retry_d    = '0;
          tx_data_d  = msg_data;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            retry_d = retry_q + RTRY_W'(1);
            // a dropped packet still consumes its slot so the burst carries on
            if (retry_q == RTRY_LAST) begin
              pkt_left_d = pkt_left_q - 2'd1;
              gap_cnt_d  = GAP_LOAD;
              state_d    = ST_GAP;
            end else begin
              state_d = ST_START;
            end
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          pkt_left_d = pkt_left_q - 2'd1;
          gap_cnt_d  = GAP_LOAD;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (pkt_left_q != 2'd0) begin
          tx_data_d = hi_half_q;
          retry_d   = '0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    aes_ready  = 1'b0;
    msg_ready  = 1'b0;
    tx_start   = 1'b0;
    err_drop   = 1'b0;
    burst_done = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          aes_ready = gnt_vld && (gnt_id == REQ_AES);
          msg_ready = gnt_vld && (gnt_id == REQ_MSG);
        end
        ST_START:     tx_start   = 1'b1;
        ST_WAIT_BUSY: err_drop   = !tx_busy && (wait_cnt_q == WAIT_LAST) && (retry_q == RTRY_LAST);
        ST_GAP:       burst_done = (gap_cnt_q == '0) && (pkt_left_q == 2'd0);
        default: ;
      endcase
    end
  end

  assign aes_done = burst_done && (owner_q == REQ_AES);
  assign msg_done = burst_done && (owner_q == REQ_MSG);
  assign tx_data  = tx_data_q;

endmodule
